// File: rtl/jstk2_spi_responder_if.sv
// SPI link between the joystick master and the JSTK2 responder.
// The master drives SS/SCLK/MOSI; the responder drives MISO.
interface jstk2_spi_responder_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS, output SCLK, output MOSI, input MISO);
    modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 responder emulating the Pmod JSTK2: serves a 40-bit position/button frame, captures the command byte.
// Define JSTK2_LED_CMD_EN to accept the 0x84 LED command into led_rgb; otherwise led_rgb is tied to zero.
//
// state     | meaning
// WAIT_IDLE | after reset, waits for a settled SS high so a frame in flight is never joined
// IDLE      | SS high, MISO low, waiting for SS fall
// ACTIVE    | frame in progress, shifting on synchronised SCLK edges
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    jstk2_spi_responder_if.slave    spi,
    input  logic [9:0]              x_pos,
    input  logic [9:0]              y_pos,
    input  logic [1:0]              btn,
    output logic [7:0]              cmd_byte,
    output logic                    cmd_valid,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [23:0]             led_rgb
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic ss_q, sclk_q;
    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [2:0] flush_cnt;

    logic [39:0] tx_q, tx_d;
    logic [6:0]  rx_q, rx_d;
    logic [5:0]  cnt_q, cnt_d, cnt_v;
    logic [7:0]  cmd_d;
    logic        cmd_valid_d, done_d, err_d;
    logic        miso_q, miso_d;
    logic [39:0] frame;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_q & ~ss_s;
    assign ss_rise   = ~ss_q & ss_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    assign frame = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 6'b0, btn};

    assign spi.MISO = miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            ss_q      <= ss_s;
            sclk_q    <= sclk_s;
        end
    end

    // The synchroniser resets to SS high, so hold off until real pin values have flushed through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 3'(SYNC_STAGES + 1);
        end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            cmd_byte   <= '0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            cmd_byte   <= cmd_d;
            cmd_valid  <= cmd_valid_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            miso_q     <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        cnt_v       = cnt_q;
        cmd_d       = cmd_byte;
        cmd_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        miso_d      = miso_q;
        case (state_q)
            WAIT_IDLE: begin
                miso_d = 1'b0;
                if (flush_cnt == 3'd0 && ss_s) state_d = IDLE;
            end
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    tx_d    = frame;
                    cnt_d   = '0;
                    miso_d  = frame[39];
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_d = {rx_q[5:0], mosi_s};
                    if (cnt_q != 6'd63) cnt_v = cnt_q + 6'd1;
                    cnt_d = cnt_v;
                    if (cnt_q == 6'd7) begin
                        cmd_d       = {rx_q, mosi_s};
                        cmd_valid_d = 1'b1;
                    end
                end
                if (sclk_fall) begin
                    tx_d   = {tx_q[38:0], 1'b0};
                    miso_d = tx_q[38];
                end
                // End-of-frame check sees the count including a same-cycle rising edge.
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    if (cnt_v == 6'd40) done_d = 1'b1;
                    else                err_d  = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

`ifdef JSTK2_LED_CMD_EN
    logic [23:0] stage_q;
    logic [23:0] led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            led_q   <= '0;
        end else begin
            if (state_q == ACTIVE && sclk_rise && cnt_q >= 6'd8 && cnt_q < 6'd32)
                stage_q <= {stage_q[22:0], mosi_s};
            if (done_d && cmd_d == 8'h84)
                led_q <= stage_q;
        end
    end

    assign led_rgb = led_q;
`else
    assign led_rgb = 24'h0;
`endif

    a_done_len: assert property (@(posedge clk) disable iff (rst)
        frame_done |-> (cnt_q == 6'(FRAME_BITS)));

endmodule
